// File: rtl/fc_score_unit.sv
// fc_score_unit
//   Final fully-connected stage. For each class it runs a multiply-accumulate
//   over IN_LEN features and weights read from external synchronous memories.
//   It then scales and saturates the sum and keeps the score in an internal
//   buffer. After the last class, all scores go out as one gap-free burst.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start_sign  frame start, sampled only while idle
//   feat_addr   feature memory address (registered)
//   feat_data   signed feature, valid one cycle after feat_addr
//   w_addr      weight memory address, cls*IN_LEN+idx (registered)
//   w_data      signed weight, valid one cycle after w_addr
//   data_out    signed DW+1-bit score for the comparator
//   read_en     high on every beat of the score burst
//   address     class index of data_out, 0 outside the burst
//   busy        high from start acceptance until done
//   done        one-cycle pulse in the cycle after the last beat
module fc_score_unit #(
   parameter int DW        = 8,
   parameter int IN_LEN    = 16,
   parameter int NUM_CLASS = 14,
   parameter int MEM_ADDR  = 4,
   parameter int FEAT_ADDR = 4,
   parameter int W_ADDR    = 8,
   parameter int ACC_W     = 20,
   parameter int SHIFT     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start_sign,
   output logic [FEAT_ADDR-1:0]        feat_addr,
   input  logic signed [DW-1:0]        feat_data,
   output logic [W_ADDR-1:0]           w_addr,
   input  logic signed [DW-1:0]        w_data,
   output logic signed [DW:0]          data_out,
   output logic                        read_en,
   output logic [MEM_ADDR-1:0]         address,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic [1:0] {IDLE, MAC, STORE, STREAM} state_t;

   localparam int CNT_W = $clog2(IN_LEN + 1);
   localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(IN_LEN);
   localparam logic [CNT_W-1:0]    LAST_ISSUE = CNT_W'(IN_LEN - 1);
   localparam logic [MEM_ADDR-1:0] LAST_CLS   = MEM_ADDR'(NUM_CLASS - 1);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << DW) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << DW));

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg;
   logic [CNT_W-1:0]          cnt_inc;
   logic [MEM_ADDR-1:0]       cls_reg;
   logic [W_ADDR-1:0]         w_base_reg;
   logic                      issue_reg;   // an address is on the memory bus this cycle
   logic                      valid_reg;   // memory data for that address is valid now
   logic signed [ACC_W-1:0]   acc_reg;
   logic signed [DW:0]        score_buf [NUM_CLASS];

   logic signed [2*DW-1:0]    prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   shifted;
   logic signed [DW:0]        score_sat;

   assign cnt_inc  = cnt_reg + CNT_W'(1);
   assign prod     = feat_data * w_data;
   assign prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
   assign shifted  = acc_reg >>> SHIFT;

   always_comb begin
      score_sat = shifted[DW:0];
      if (shifted > SAT_HI)
         score_sat = SAT_HI[DW:0];
      else if (shifted < SAT_LO)
         score_sat = SAT_LO[DW:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:   if (start_sign) state_next = MAC;
         MAC:    if (cnt_reg == LAST_CNT) state_next = STORE;
         STORE:  state_next = (cls_reg == LAST_CLS) ? STREAM : MAC;
         STREAM: if (address == LAST_CLS) state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         feat_addr  <= '0;
         w_addr     <= '0;
         data_out   <= '0;
         read_en    <= 1'b0;
         address    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cnt_reg    <= '0;
         cls_reg    <= '0;
         w_base_reg <= '0;
         issue_reg  <= 1'b0;
         valid_reg  <= 1'b0;
         acc_reg    <= '0;
         for (int i = 0; i < NUM_CLASS; i++)
            score_buf[i] <= '0;
      end else begin
         done      <= 1'b0;
         valid_reg <= issue_reg;
         if (valid_reg)
            acc_reg <= acc_reg + prod_ext;

         unique case (state_reg)
            IDLE: begin
               if (start_sign) begin
                  busy       <= 1'b1;
                  cls_reg    <= '0;
                  cnt_reg    <= '0;
                  w_base_reg <= '0;
                  acc_reg    <= '0;
                  feat_addr  <= '0;
                  w_addr     <= '0;
                  issue_reg  <= 1'b1;
               end
            end
            MAC: begin
               cnt_reg <= cnt_inc;
               // Issue idx+1 while idx < IN_LEN-1; the remaining cycles
               // drain the one-cycle memory latency.
               if (cnt_reg < LAST_ISSUE) begin
                  feat_addr <= FEAT_ADDR'(cnt_inc);
                  w_addr    <= w_base_reg + W_ADDR'(cnt_inc);
               end else begin
                  issue_reg <= 1'b0;
                  feat_addr <= '0;
                  w_addr    <= '0;
               end
            end
            STORE: begin
               score_buf[cls_reg] <= score_sat;
               acc_reg            <= '0;
               if (cls_reg == LAST_CLS) begin
                  read_en  <= 1'b1;
                  address  <= '0;
                  // With a single class, buf[0] is being written on this edge.
                  data_out <= (NUM_CLASS == 1) ? score_sat : score_buf[0];
               end else begin
                  cls_reg    <= cls_reg + MEM_ADDR'(1);
                  w_base_reg <= w_base_reg + W_ADDR'(IN_LEN);
                  w_addr     <= w_base_reg + W_ADDR'(IN_LEN);
                  feat_addr  <= '0;
                  cnt_reg    <= '0;
                  issue_reg  <= 1'b1;
               end
            end
            STREAM: begin
               if (address == LAST_CLS) begin
                  read_en  <= 1'b0;
                  address  <= '0;
                  data_out <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  address  <= address + MEM_ADDR'(1);
                  data_out <= score_buf[address + MEM_ADDR'(1)];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_score_unit.sv
// Testbench for fc_score_unit: synchronous feature/weight memories,
// directed and random frames, scores checked against an arithmetic model.
module tb_fc_score_unit;
   localparam int DW        = 8;
   localparam int IN_LEN    = 16;
   localparam int NUM_CLASS = 14;
   localparam int MEM_ADDR  = 4;
   localparam int FEAT_ADDR = 4;
   localparam int W_ADDR    = 8;
   localparam int ACC_W     = 20;
   localparam int SHIFT     = 4;
   localparam int LATENCY   = NUM_CLASS * (IN_LEN + 2);

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   start_sign = 1'b0;
   logic [FEAT_ADDR-1:0]   feat_addr;
   logic signed [DW-1:0]   feat_data = '0;
   logic [W_ADDR-1:0]      w_addr;
   logic signed [DW-1:0]   w_data = '0;
   logic signed [DW:0]     data_out;
   logic                   read_en;
   logic [MEM_ADDR-1:0]    address;
   logic                   busy;
   logic                   done;

   fc_score_unit #(
      .DW(DW), .IN_LEN(IN_LEN), .NUM_CLASS(NUM_CLASS), .MEM_ADDR(MEM_ADDR),
      .FEAT_ADDR(FEAT_ADDR), .W_ADDR(W_ADDR), .ACC_W(ACC_W), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .reset(reset), .start_sign(start_sign),
      .feat_addr(feat_addr), .feat_data(feat_data),
      .w_addr(w_addr), .w_data(w_data),
      .data_out(data_out), .read_en(read_en), .address(address),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic signed [DW-1:0] feat_mem [IN_LEN];
   logic signed [DW-1:0] w_mem    [1 << W_ADDR];

   // One-cycle synchronous read memories.
   always @(posedge clk) begin
      feat_data <= feat_mem[feat_addr];
      w_data    <= w_mem[w_addr];
   end

   int checks = 0;
   int errors = 0;
   int exp_score [NUM_CLASS];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
         $error("check %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // mode 0: features 1, weights = class index
   // mode 1: features 127, weights 127 for class 5 only
   // mode 2: features 127, weights -128
   // mode 3: fully random
   // mode 4: random features, small random weights
   task automatic load_mem(input int mode);
      for (int i = 0; i < IN_LEN; i++) begin
         case (mode)
            0:       feat_mem[i] = 8'sd1;
            1, 2:    feat_mem[i] = 8'sd127;
            default: feat_mem[i] = 8'($urandom_range(0, 255));
         endcase
      end
      for (int a = 0; a < (1 << W_ADDR); a++) begin
         int c;
         c = a / IN_LEN;
         if (c >= NUM_CLASS) w_mem[a] = '0;
         else case (mode)
            0:       w_mem[a] = 8'(c);
            1:       w_mem[a] = (c == 5) ? 8'sd127 : 8'sd0;
            2:       w_mem[a] = -8'sd128;
            3:       w_mem[a] = 8'($urandom_range(0, 255));
            default: w_mem[a] = 8'(int'($urandom_range(0, 6)) - 3);
         endcase
      end
   endtask

   // Reference: dot product, arithmetic shift, clamp to [-2^DW, 2^DW-1].
   task automatic compute_expected();
      for (int c = 0; c < NUM_CLASS; c++) begin
         int sum;
         int s;
         sum = 0;
         for (int i = 0; i < IN_LEN; i++)
            sum += int'(feat_mem[i]) * int'(w_mem[c*IN_LEN + i]);
         s = sum >>> SHIFT;
         if (s > (1 << DW) - 1) s = (1 << DW) - 1;
         if (s < -(1 << DW))    s = -(1 << DW);
         exp_score[c] = s;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".feat_addr"}, int'(feat_addr), 0);
      chk({tag, ".w_addr"},    int'(w_addr),    0);
      chk({tag, ".data_out"},  int'(data_out),  0);
      chk({tag, ".read_en"},   int'(read_en),   0);
      chk({tag, ".address"},   int'(address),   0);
      chk({tag, ".busy"},      int'(busy),      0);
      chk({tag, ".done"},      int'(done),      0);
   endtask

   // Starts a frame from an idle cycle and checks it; returns positioned in
   // the done cycle (or two cycles later when end_pulse is set).
   task automatic run_frame(input string name, input bit end_pulse);
      int n;
      int a13;
      start_sign = 1'b1;
      tick();
      start_sign = 1'b0;
      chk({name, ".busy_start"}, int'(busy), 1);
      chk({name, ".done_low"},   int'(done), 0);
      n = 0;
      a13 = 0;
      while (read_en !== 1'b1 && n < LATENCY + 50) begin
         if (n == 100) start_sign = 1'b1;   // must be ignored while busy
         tick();
         start_sign = 1'b0;
         n++;
         if (int'(address) == NUM_CLASS - 1) a13++;
      end
      chk({name, ".latency"}, n, LATENCY);
      for (int k = 0; k < NUM_CLASS; k++) begin
         chk($sformatf("%s.read_en[%0d]", name, k),  int'(read_en),  1);
         chk($sformatf("%s.address[%0d]", name, k),  int'(address),  k);
         chk($sformatf("%s.data_out[%0d]", name, k), int'(data_out), exp_score[k]);
         if (k > 0 && int'(address) == NUM_CLASS - 1) a13++;
         if (end_pulse && k == NUM_CLASS - 1) start_sign = 1'b1;
         tick();
         start_sign = 1'b0;
      end
      chk({name, ".done"},     int'(done),     1);
      chk({name, ".busy_end"}, int'(busy),     0);
      chk({name, ".rd_end"},   int'(read_en),  0);
      chk({name, ".addr_end"}, int'(address),  0);
      chk({name, ".data_end"}, int'(data_out), 0);
      chk({name, ".addr13_count"}, a13, 1);
      if (end_pulse) begin
         tick();
         chk({name, ".no_restart_busy"}, int'(busy), 0);
         chk({name, ".done_pulse"},      int'(done), 0);
         tick();
         chk({name, ".still_idle"}, int'(busy), 0);
      end
   endtask

   initial begin
      load_mem(3);
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();
      check_all_zero("idle");

      load_mem(0); compute_expected(); run_frame("ramp", 1'b0);
      load_mem(1); compute_expected(); run_frame("sat_pos", 1'b0);
      load_mem(2); compute_expected(); run_frame("sat_neg", 1'b1);
      load_mem(3); compute_expected(); run_frame("rand0", 1'b0);
      load_mem(4); compute_expected(); run_frame("rand1", 1'b0);

      // Reset in the middle of a frame.
      tick();
      load_mem(3); compute_expected();
      start_sign = 1'b1;
      tick();
      start_sign = 1'b0;
      repeat (130) tick();
      chk("midframe.busy", int'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (3) tick();
      check_all_zero("held_reset");
      reset = 1'b1;
      tick();
      load_mem(4); compute_expected(); run_frame("after_reset", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
